// File: rtl/score_tracker_multi_if.sv
// Frame-level signal bundle between the lane detectors, the score tracker and the HUD.
// The master side drives frame strobe, restart and lane flags; the slave side returns game state.
interface score_tracker_multi_if #(
    parameter int LANES   = 4,
    parameter int SCORE_W = 16,
    parameter int LW      = 4,
    parameter int COMBO_W = 8
);
    logic               Frame_Clk;
    logic               Restart;
    logic [LANES-1:0]   Hit;
    logic [LANES-1:0]   Dropped;
    logic [SCORE_W-1:0] Score;
    logic [LW-1:0]      Lives;
    logic [COMBO_W-1:0] Combo;
    logic [2:0]         Multiplier;
    logic [SCORE_W-1:0] High_Score;
    logic               Game_Over;
    logic               Extra_Life;

    modport master (
        output Frame_Clk, Restart, Hit, Dropped,
        input  Score, Lives, Combo, Multiplier, High_Score, Game_Over, Extra_Life
    );

    modport slave (
        input  Frame_Clk, Restart, Hit, Dropped,
        output Score, Lives, Combo, Multiplier, High_Score, Game_Over, Extra_Life
    );
endinterface

// File: rtl/score_tracker_multi.sv
// Multi-lane score/lives tracker: one evaluation per rising Frame_Clk edge, with combo multiplier,
// extra-life bonuses, a PLAY/OVER state machine and a session high score that survives Restart.
module score_tracker_multi #(
    parameter int LANES      = 4,
    parameter int SCORE_W    = 16,
    parameter int LIVES_INIT = 10,
    parameter int LIVES_MAX  = 15,
    parameter int COMBO_W    = 8,
    parameter int COMBO_STEP = 4,
    parameter int MULT_MAX   = 4,
    parameter int BONUS_STEP = 100
) (
    input logic                  Clk,
    input logic                  Reset,
    score_tracker_multi_if.slave bus
);
    localparam int LW  = $clog2(LIVES_MAX + 1);
    localparam int LSW = LW + 2;
    localparam int CW  = $clog2(LANES + 1);
    localparam int SW  = SCORE_W + CW + 3;

    typedef enum logic {PLAY, OVER} state_t;

    state_t             state;
    logic               frame_clk_old;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] high_score;
    logic [SCORE_W-1:0] next_bonus;
    logic [LW-1:0]      lives;
    logic [COMBO_W-1:0] combo;
    logic               game_over;
    logic               extra_life;

    logic                  frame_evt;
    logic [CW-1:0]         hits;
    logic [CW-1:0]         drops;
    logic [COMBO_W-1:0]    mult_step;
    logic [2:0]            mult;
    logic [SW-1:0]         score_sum;
    logic [SCORE_W-1:0]    score_n;
    logic [SCORE_W-1:0]    high_score_n;
    logic [SCORE_W:0]      bonus_sum;
    logic [SCORE_W-1:0]    next_bonus_n;
    logic                  bonus;
    logic signed [LSW-1:0] lives_sum;
    logic [LW-1:0]         lives_n;
    logic [COMBO_W-1:0]    combo_n;

    // A strobe already high when reset releases is not an edge, hence old resets to 1.
    assign frame_evt = bus.Frame_Clk & ~frame_clk_old;

    // NOTE: both counters get a default before the loop, so no path can leave them unassigned.
    always_comb begin
        hits  = '0;
        drops = '0;
        for (int i = 0; i < LANES; i++) begin
            hits  = hits + CW'(bus.Hit[i]);
            drops = drops + CW'(bus.Dropped[i]);
        end
    end

    // The multiplier always reflects the pre-frame combo.
    assign mult_step = combo / COMBO_W'(COMBO_STEP);
    assign mult      = (mult_step >= COMBO_W'(MULT_MAX - 1)) ? 3'(MULT_MAX)
                                                              : 3'(mult_step + COMBO_W'(1));

    assign score_sum    = SW'(score) + SW'(hits) * SW'(mult);
    assign score_n      = (|score_sum[SW-1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];
    assign high_score_n = (score_n > high_score) ? score_n : high_score;

    assign bonus        = (score_n >= next_bonus);
    assign bonus_sum    = {1'b0, next_bonus} + (SCORE_W+1)'(BONUS_STEP);
    assign next_bonus_n = bonus_sum[SCORE_W] ? '1 : bonus_sum[SCORE_W-1:0];

    // Signed headroom so a multi-lane drop clamps at zero instead of wrapping.
    assign lives_sum = $signed(LSW'(lives)) + $signed(LSW'(bonus)) - $signed(LSW'(drops));
    assign lives_n   = lives_sum[LSW-1]                        ? '0 :
                       (lives_sum > $signed(LSW'(LIVES_MAX))) ? LW'(LIVES_MAX) :
                                                                lives_sum[LW-1:0];

    assign combo_n = (drops != '0) ? '0 :
                     (hits == '0)  ? combo :
                     (combo == '1) ? combo : combo + COMBO_W'(1);

    // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= PLAY;
            frame_clk_old <= 1'b1;
            score         <= '0;
            high_score    <= '0;
            next_bonus    <= SCORE_W'(BONUS_STEP);
            lives         <= LW'(LIVES_INIT);
            combo         <= '0;
            game_over     <= 1'b0;
            extra_life    <= 1'b0;
        end else begin
            frame_clk_old <= bus.Frame_Clk;
            extra_life    <= 1'b0;
            if (bus.Restart) begin
                high_score <= (score > high_score) ? score : high_score;
                score      <= '0;
                lives      <= LW'(LIVES_INIT);
                combo      <= '0;
                next_bonus <= SCORE_W'(BONUS_STEP);
                state      <= PLAY;
                game_over  <= 1'b0;
            end else if (frame_evt && state == PLAY) begin
                score      <= score_n;
                lives      <= lives_n;
                combo      <= combo_n;
                extra_life <= bonus;
                if (bonus) begin
                    next_bonus <= next_bonus_n;
                end
                if (lives_n == '0) begin
                    state      <= OVER;
                    game_over  <= 1'b1;
                    high_score <= high_score_n;
                end
            end
        end
    end

    assign bus.Score      = score;
    assign bus.Lives      = lives;
    assign bus.Combo      = combo;
    assign bus.Multiplier = mult;
    assign bus.High_Score = high_score;
    assign bus.Game_Over  = game_over;
    assign bus.Extra_Life = extra_life;
endmodule
